// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder: valid/ready word intake, MSB-first bit stream with sof/eof markers.
// Optional SER_MOD3_CHECK_EN adds a registered per-word divisible-by-3 reference (div3_chk/div3_chk_valid).
module serial_word_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             sof,
`ifdef SER_MOD3_CHECK_EN
  output logic             eof,
  output logic             div3_chk,
  output logic             div3_chk_valid
`else
  output logic             eof
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Ready is decoded from registers only, so a new word can land exactly on the eof cycle.
  always_comb begin
    in_ready  = (state == IDLE) || (cnt == '0);
    out       = 1'b0;
    out_valid = 1'b0;
    sof       = 1'b0;
    eof       = 1'b0;
    if (state == SHIFT) begin
      out       = sreg[WIDTH-1];
      out_valid = 1'b1;
      sof       = (cnt == CNT_TOP);
      eof       = (cnt == '0);
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    if (accept) begin
      sreg_nxt  = in_data;
      cnt_nxt   = CNT_TOP;
      state_nxt = SHIFT;
    end else if (state == SHIFT) begin
      if (cnt != '0) begin
        sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
        cnt_nxt  = cnt - 1'b1;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

`ifdef SER_MOD3_CHECK_EN
  logic [1:0] res;
  logic [1:0] res_nxt;

  function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
    logic [1:0] v;
    case ({r, b})
      3'b000:  v = 2'd0;
      3'b001:  v = 2'd1;
      3'b010:  v = 2'd2;
      3'b011:  v = 2'd0;
      3'b100:  v = 2'd1;
      3'b101:  v = 2'd2;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  // The residue restarts at sof so each word is judged on its own bits.
  assign res_nxt = mod3_step(sof ? 2'd0 : res, out);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res            <= 2'd0;
      div3_chk       <= 1'b0;
      div3_chk_valid <= 1'b0;
    end else begin
      if (out_valid) res <= res_nxt;
      div3_chk_valid <= eof;
      div3_chk       <= eof && (res_nxt == 2'd0);
    end
  end
`endif

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder (WIDTH=8): vector table plus hand-written reset and mod-3 sequences.
module tb_serial_word_feeder;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out;
  logic       out_valid;
  logic       sof;
  logic       eof;
`ifdef SER_MOD3_CHECK_EN
  logic       div3_chk;
  logic       div3_chk_valid;
`endif

  int checks;
  int failures;

  serial_word_feeder #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .sof       (sof),
`ifdef SER_MOD3_CHECK_EN
    .eof            (eof),
    .div3_chk       (div3_chk),
    .div3_chk_valid (div3_chk_valid)
`else
    .eof       (eof)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic [4:0] exp;  // {in_ready, out, out_valid, sof, eof}
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic vld, input logic [7:0] data, input logic [4:0] exp);
    vec_t v;
    v.rst = rst; v.vld = vld; v.data = data; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Eight shift cycles of word w; inputs during busy cycles and during the eof cycle given separately.
  task automatic add_word(input logic [7:0] w, input logic bvld, input logic [7:0] bdata,
                          input logic evld, input logic [7:0] edata);
    for (int k = 0; k < 8; k++) begin
      add(1'b0, (k == 7) ? evld : bvld, (k == 7) ? edata : bdata,
          {(k == 7), w[7-k], 1'b1, (k == 0), (k == 7)});
    end
  endtask

  function automatic logic [4:0] outs();
    return {in_ready, out, out_valid, sof, eof};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // reset held for two cycles, then idle
    add(1'b1, 1'b0, 8'h00, 5'b10000);
    add(1'b1, 1'b0, 8'h00, 5'b10000);
    add(1'b0, 1'b0, 8'h00, 5'b10000);
    // single word B4, in_valid dropped while busy
    add(1'b0, 1'b1, 8'hB4, 5'b10000);
    add_word(8'hB4, 1'b0, 8'h00, 1'b0, 8'h00);
    add(1'b0, 1'b0, 8'h00, 5'b10000);
    // 03 then 05 gapless
    add(1'b0, 1'b1, 8'h03, 5'b10000);
    add_word(8'h03, 1'b1, 8'h03, 1'b1, 8'h05);
    add_word(8'h05, 1'b0, 8'h00, 1'b0, 8'h00);
    add(1'b0, 1'b0, 8'h00, 5'b10000);
    // FF then 00 held valid while busy: not accepted before eof
    add(1'b0, 1'b1, 8'hFF, 5'b10000);
    add_word(8'hFF, 1'b1, 8'h00, 1'b1, 8'h00);
    add_word(8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    add(1'b0, 1'b0, 8'h00, 5'b10000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset    = vecs[i].rst;
      in_valid = vecs[i].vld;
      in_data  = vecs[i].data;
      #1;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // asynchronous reset in the middle of A5 after three bits
    @(negedge clk); in_valid = 1'b1; in_data = 8'hA5; #1;
    check("a5_idle", 32'(outs()), 32'(5'b10000));
    @(negedge clk); in_valid = 1'b0; #1;
    check("a5_bit7", 32'(outs()), 32'(5'b01110));
    @(negedge clk); #1;
    check("a5_bit6", 32'(outs()), 32'(5'b00100));
    @(negedge clk); #1;
    check("a5_bit5", 32'(outs()), 32'(5'b01100));
    @(posedge clk); #2;
    check("a5_bit4_pre", 32'(outs()), 32'(5'b00100));
    reset = 1'b1; #1;
    check("midreset", 32'(outs()), 32'(5'b10000));
    #1 reset = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = 8'h3C; #1;
    check("post_rst_idle", 32'(outs()), 32'(5'b10000));
    @(negedge clk); in_valid = 1'b0; #1;
    check("3c_sof", 32'(outs()), 32'(5'b00110));
    @(negedge clk); #1;
    check("3c_bit6", 32'(outs()), 32'(5'b00100));
    @(negedge clk); #1;
    check("3c_bit5", 32'(outs()), 32'(5'b01100));
    repeat (6) @(negedge clk);
    #1;
    check("3c_done", 32'(outs()), 32'(5'b10000));

`ifdef SER_MOD3_CHECK_EN
    begin
      logic [7:0] words [3];
      logic       expc  [3];
      words[0] = 8'hB4; words[1] = 8'h05; words[2] = 8'h00;
      expc[0]  = 1'b1;  expc[1]  = 1'b0;  expc[2]  = 1'b1;
      for (int c = 0; c < 28; c++) begin
        logic ev, ec;
        @(negedge clk);
        in_valid = (c < 24);
        in_data  = (c < 24) ? words[c/8] : 8'h00;
        #1;
        ev = (c >= 9) && (c <= 25) && (((c - 9) % 8) == 0);
        ec = ev ? expc[(c - 9) / 8] : 1'b0;
        check($sformatf("mod3_c%0d", c), 32'({div3_chk_valid, div3_chk}), 32'({ev, ec}));
      end
    end
`endif

    in_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
